// File: rtl/axil_led_regs.sv
// AXI4-Lite slave with four registers driving a 4-bit LED port.
// LED_OUT and BLINK_MASK combine with a prescaled blink phase; BLINK_DIV
// sets the half period and ID is a read-only constant.
module axil_led_regs #(
  parameter logic [31:0] ID_VALUE = 32'h4C45_4401
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [3:0]  leds_4bits_tri_o
);

  localparam logic [1:0] IDX_LED   = 2'd0;
  localparam logic [1:0] IDX_MASK  = 2'd1;
  localparam logic [1:0] IDX_DIV   = 2'd2;

  logic        rdy_en_r;
  logic        aw_held_r;
  logic [1:0]  aw_idx_r;
  logic        w_held_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        bvalid_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [3:0]  led_out_r;
  logic [3:0]  blink_mask_r;
  logic [31:0] blink_div_r;
  logic [31:0] cnt_r;
  logic        phase_r;
  logic [3:0]  leds_r;

  logic        aw_hs_s;
  logic        w_hs_s;
  logic        ar_hs_s;
  logic        commit_s;
  logic        div_wr_s;
  logic [31:0] rd_mux_s;

  // Ready signals stay low in reset and during the first edge after release.
  assign s_axi_awready = rdy_en_r & ~aw_held_r & ~bvalid_r;
  assign s_axi_wready  = rdy_en_r & ~w_held_r & ~bvalid_r;
  assign s_axi_arready = rdy_en_r & ~rvalid_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = 2'b00;
  assign leds_4bits_tri_o = leds_r;

  assign aw_hs_s  = s_axi_awvalid & s_axi_awready;
  assign w_hs_s   = s_axi_wvalid & s_axi_wready;
  assign ar_hs_s  = s_axi_arvalid & s_axi_arready;
  assign commit_s = aw_held_r & w_held_r;
  assign div_wr_s = commit_s & (aw_idx_r == IDX_DIV) & (|wstrb_r);

  // Capture AW and W independently; once both are held, commit and raise B.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_r  <= 1'b0;
      aw_held_r <= 1'b0;
      aw_idx_r  <= 2'd0;
      w_held_r  <= 1'b0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      bvalid_r  <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (commit_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_idx_r  <= s_axi_awaddr[3:2];
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          wdata_r  <= s_axi_wdata;
          wstrb_r  <= s_axi_wstrb;
        end
        if (bvalid_r && s_axi_bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Apply a committed write to the addressed register under its byte strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      led_out_r    <= 4'd0;
      blink_mask_r <= 4'd0;
      blink_div_r  <= 32'd0;
    end else if (commit_s) begin
      case (aw_idx_r)
        IDX_LED: begin
          if (wstrb_r[0]) led_out_r <= wdata_r[3:0];
        end
        IDX_MASK: begin
          if (wstrb_r[0]) blink_mask_r <= wdata_r[3:0];
        end
        IDX_DIV: begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_r[b]) blink_div_r[8*b +: 8] <= wdata_r[8*b +: 8];
          end
        end
        default: begin
          // ID is read-only: the write is acknowledged and dropped.
        end
      endcase
    end
  end

  // Blink prescaler; a BLINK_DIV write restarts it so no wrap past 2^32 occurs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b0;
    end else if (div_wr_s || (blink_div_r == 32'd0)) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b0;
    end else if (cnt_r == blink_div_r) begin
      cnt_r   <= 32'd0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // Registered LED drive: static pattern with masked bits inverted by phase.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      leds_r <= 4'd0;
    end else begin
      leds_r <= led_out_r ^ (blink_mask_r & {4{phase_r}});
    end
  end

  // Read-data selection from current (pre-update) register values.
  always_comb begin
    rd_mux_s = 32'd0;
    case (s_axi_araddr[3:2])
      IDX_LED:  rd_mux_s = {28'd0, led_out_r};
      IDX_MASK: rd_mux_s = {28'd0, blink_mask_r};
      IDX_DIV:  rd_mux_s = blink_div_r;
      default:  rd_mux_s = ID_VALUE;
    endcase
  end

  // Read channel: register data on AR handshake and hold it until rready.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'd0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_mux_s;
    end else if (rvalid_r && s_axi_rready) begin
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= rvalid_r;
    end
  end

endmodule

// File: tb/tb_axil_led_regs.sv
// Self-checking bench for axil_led_regs: a write/readback vector table plus
// hand-written sequences for handshake ordering, blinking, stalls and reset.
module tb_axil_led_regs;

  localparam logic [31:0] ID = 32'h4C45_4401;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awaddr = 4'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = 4'd0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  leds;

  int passed = 0;
  int total  = 0;

  axil_led_regs #(.ID_VALUE(ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .leds_4bits_tri_o(leds)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // Wait (at negedges) until cond is high, bounded; returns 1 on success.
  task automatic wait_bvalid(output bit ok);
    int n = 0;
    @(negedge aclk);
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    ok = bvalid;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bit ok;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) check("write_ready_timeout", 32'd0, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    wait_bvalid(ok);
    if (!ok) check("bvalid_timeout", 32'd0, 32'd1);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) check("arready_timeout", 32'd0, 32'd1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) check("rvalid_timeout", 32'd0, 32'd1);
    d = rdata;
    tick();
    rready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    bit ok;
    int trans[$];
    logic prev;
    int n;

    // ---- reset state ----
    repeat (3) @(negedge aclk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_leds",    {28'd0, leds},    32'd0);
    aresetn = 1'b1;
    tick();
    check("ready_after_release", {29'd0, awready, wready, arready}, 32'd7);

    // ---- AW+W same cycle: B one cycle later, leds one cycle after that ----
    awaddr = 4'h0; wdata = 32'h0000_0005; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_not_yet", {31'd0, bvalid}, 32'd0);
    tick();
    check("b_latency", {31'd0, bvalid}, 32'd1);
    check("bresp", {30'd0, bresp}, 32'd0);
    check("leds_not_yet", {28'd0, leds}, 32'd0);
    tick();
    check("leds_5", {28'd0, leds}, 32'd5);
    check("b_held", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_cleared", {31'd0, bvalid}, 32'd0);

    // ---- W three cycles before AW ----
    awaddr = 4'h4; wdata = 32'h0000_000F; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w_first_wready_low", {31'd0, wready}, 32'd0);
      check("w_first_no_b", {31'd0, bvalid}, 32'd0);
      if (i < 2) tick();
    end
    check("w_first_awready", {31'd0, awready}, 32'd1);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0; bready = 1'b1;
    check("w_first_b_wait", {31'd0, bvalid}, 32'd0);
    tick();
    check("w_first_b", {31'd0, bvalid}, 32'd1);
    tick();
    bready = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bvalid) n++;
      tick();
    end
    check("single_b", n, 32'd0);
    axi_read(4'h4, rd);
    check("mask_F", rd, 32'h0000_000F);

    // ---- vector table: write then read back ----
    vecs[0]  = '{4'h0, 32'h0000_0005, 4'hF, 32'h0000_0005};
    vecs[1]  = '{4'h0, 32'hFFFF_FFFA, 4'hF, 32'h0000_000A};
    vecs[2]  = '{4'h0, 32'h0000_0003, 4'hE, 32'h0000_000A};
    vecs[3]  = '{4'h4, 32'h0000_000F, 4'hF, 32'h0000_000F};
    vecs[4]  = '{4'h4, 32'h1234_5670, 4'h1, 32'h0000_0000};
    vecs[5]  = '{4'h8, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
    vecs[6]  = '{4'h8, 32'h1122_3344, 4'h5, 32'hAA22_CC44};
    vecs[7]  = '{4'hC, 32'hDEAD_BEEF, 4'hF, ID};
    vecs[8]  = '{4'h9, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[9]  = '{4'h8, 32'hAABB_CCDD, 4'h5, 32'h00BB_00DD};
    vecs[10] = '{4'h1, 32'h0000_0000, 4'hF, 32'h0000_0000};
    vecs[11] = '{4'h8, 32'h0000_0000, 4'hF, 32'h0000_0000};
    for (int i = 0; i < 12; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_readback", i), rd, vecs[i].exp_rd);
    end

    // ---- blinking: DIV=3, MASK=1, LED_OUT=0 -> 4-cycle half period ----
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    @(negedge aclk);
    prev = leds[0];
    for (int c = 1; c < 40; c++) begin
      @(negedge aclk);
      if (leds[0] != prev) trans.push_back(c);
      prev = leds[0];
    end
    check("blink_transitions", (trans.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 1; k < trans.size(); k++)
      check($sformatf("blink_period%0d", k), trans[k] - trans[k-1], 32'd4);
    check("blink_upper_leds", {28'd0, leds[3:1], 1'b0}, 32'd0);
    tick();
    axi_write(4'h8, 32'h0, 4'hF);
    tick(); tick();
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      if (leds[0]) n++;
    end
    check("blink_stopped", n, 32'd0);
    tick();

    // ---- read ID with rready held low for 5 cycles ----
    araddr = 4'hC; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("id_rvalid", {31'd0, rvalid}, 32'd1);
      check("id_rdata", rdata, ID);
      check("id_arready_low", {31'd0, arready}, 32'd0);
      check("id_rresp", {30'd0, rresp}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("id_rvalid_clr", {31'd0, rvalid}, 32'd0);
    check("id_arready_back", {31'd0, arready}, 32'd1);

    // ---- read in the same cycle as the write update sees old value ----
    axi_write(4'h0, 32'h6, 4'hF);
    awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    check("rw_same_edge_b", {31'd0, bvalid}, 32'd1);
    check("rw_same_edge_old", rdata, 32'h6);
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h0, rd);
    check("rw_new_value", rd, 32'h9);
    tick();
    check("leds_9", {28'd0, leds}, 32'd9);

    // ---- reset while bvalid is pending ----
    axi_write(4'h8, 32'h55, 4'hF);
    awaddr = 4'h4; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid(ok);
    check("pend_bvalid", {31'd0, bvalid}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_bvalid_drop", {31'd0, bvalid}, 32'd0);
    check("rst_leds_zero", {28'd0, leds}, 32'd0);
    check("rst_awready_low", {31'd0, awready}, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    tick();
    tick();
    check("post_rst_no_b", {31'd0, bvalid}, 32'd0);
    axi_read(4'h0, rd);
    check("post_rst_led", rd, 32'd0);
    axi_read(4'h4, rd);
    check("post_rst_mask", rd, 32'd0);
    axi_read(4'h8, rd);
    check("post_rst_div", rd, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
